// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter putting two requesters onto one single-port shared BRAM.
// Optional macro SHARED_LOCK_EN adds a_lock/b_lock ports and a lock owner.
module shared_mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
`ifdef SHARED_LOCK_EN
    input  logic              a_lock,
    input  logic              b_lock,
`endif
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    // Requester identity: 0 = A (physics), 1 = B (laser).
    logic [1:0]        r_state;
    logic              r_winner;
    logic              r_last_grant;
    logic              r_we;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    logic w_a_cand;
    logic w_b_cand;
    logic w_grant_valid;
    logic w_grant_b;
    logic w_resp;

`ifdef SHARED_LOCK_EN
    logic r_owned;
    logic r_owner;
    logic w_owner_lock;
    logic w_lock_hold;
    logic w_winner_lock;

    assign w_owner_lock  = r_owner ? b_lock : a_lock;
    assign w_lock_hold   = r_owned & w_owner_lock;
    assign w_a_cand      = a_req & ~(w_lock_hold & r_owner);
    assign w_b_cand      = b_req & ~(w_lock_hold & ~r_owner);
    assign w_winner_lock = w_grant_b ? b_lock : a_lock;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_owned <= 1'b0;
            r_owner <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_grant_valid && w_winner_lock) begin
                r_owned <= 1'b1;
                r_owner <= w_grant_b;
            end else if (r_owned && !w_owner_lock) begin
                r_owned <= 1'b0;
            end
        end
    end
`else
    assign w_a_cand = a_req;
    assign w_b_cand = b_req;
`endif

    // On a tie the requester that was not served last wins.
    assign w_grant_valid = w_a_cand | w_b_cand;
    assign w_grant_b     = w_b_cand & (~w_a_cand | ~r_last_grant);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_winner     <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_a_rdata    <= '0;
            r_b_rdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_winner    <= w_grant_b;
                        r_we        <= w_grant_b ? b_we : a_we;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_grant_b ? b_we : a_we;
                        r_mem_addr  <= w_grant_b ? b_addr : a_addr;
                        r_mem_wdata <= w_grant_b ? b_wdata : a_wdata;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    if (!r_we) begin
                        if (r_winner) r_b_rdata <= mem_rdata;
                        else          r_a_rdata <= mem_rdata;
                    end
                    r_last_grant <= r_winner;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: ack is qualified by reset so a transaction abandoned in RESP never acks.
    assign w_resp = (r_state == S_RESP) & reset;
    assign a_ack  = w_resp & ~r_winner;
    assign b_ack  = w_resp & r_winner;

    // NOTE: BRAM data is forwarded during the ack cycle so rdata is valid alongside ack.
    assign a_rdata = (a_ack && !r_we) ? mem_rdata : r_a_rdata;
    assign b_rdata = (b_ack && !r_we) ? mem_rdata : r_b_rdata;

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != S_IDLE);

endmodule
